apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers. It is the initiator end of the APB link and drives the same psel/penable/pwrite/paddr/pwdata bus that our APB slave blocks decode. Each command produces one response pulse carrying read data and an error flag.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, read/write data width
- TIMEOUT_CYC, 16, ACCESS wait-state limit; used only with the timeout feature

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on a clk edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  pslverr or timeout
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data
- prdata  in  DATA_W; pready  in  1; pslverr  in  1  APB completer returns. Slaves without pready tie it to 1.

## Operation
- FSM states: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
- IDLE: psel=0, penable=0, cmd_ready=1. On accept: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, go SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0. Unconditionally go ACCESS.
- ACCESS: psel=1, penable=1. With pready=0, stay (wait state) and hold all bus outputs stable.
- Completion is a clk edge in ACCESS with pready=1. At that edge: rsp_valid<=1, rsp_err<=pslverr, rsp_rdata<=(read && !pslverr) ? prdata : 0.
- cmd_ready = (state==IDLE) || (state==ACCESS && pready). It is combinational on pready. On completion: if a command is accepted, latch it and go to SETUP (back-to-back, psel stays 1). Otherwise go to IDLE.
- rsp_valid is high for exactly one cycle per command. There is no response backpressure.
- In IDLE, paddr/pwdata/pwrite hold their last values.
- Unused encoding 2'b11 returns to IDLE.

## Timing
- Reset (asynchronous): state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0.
- Accept at edge T0, then SETUP during T0–T1, then ACCESS from T1. With pready=1 at T1 the completion edge is T2, and rsp_valid is high during T2–T3.
- Zero-wait latency from accept edge to rsp_valid is 2 cycles. Each wait state adds 1 cycle.
- Back-to-back throughput is 2 cycles per transfer.
- Reset asserted mid-transfer: the bus drops immediately and no response is issued for the aborted command.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on ACCESS entry and increments on each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC, at the next edge: rsp_valid=1, rsp_err=1, rsp_rdata=0, go IDLE.
  - cmd_ready stays 0 on the timeout cycle, so no back-to-back accept occurs.
- APB_MASTER_TIMEOUT_EN undefined: ACCESS waits indefinitely and no counter logic exists.

## Structure
- apb_pkg:
  - apb_state_t enum with IDLE/SETUP/ACCESS encodings.
  - Default ADDR_W/DATA_W constants.
- Sub-module apb_master_timer: timeout counter with clear/enable/expired ports. It is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write 0x5A to 0x10 with pready=1: psel high 2 cycles, penable high 1 cycle, paddr=0x10, pwdata=0x5A; rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x20 with prdata=0xC3 and 3 wait states: ACCESS lasts 4 cycles with the bus stable; rsp_rdata=0xC3, latency 5.
- Back-to-back write 0x01 then read 0x02, cmd_valid held: psel stays 1 across both; second SETUP follows first completion directly; two rsp_valid pulses 2 cycles apart.
- Read with pslverr=1 at completion: rsp_err=1, rsp_rdata=0.
- With the macro on and TIMEOUT_CYC=4, pready held 0: after 4 wait cycles rsp_err=1 and the FSM returns to IDLE. With the macro off, psel remains 1 indefinitely.
- rst low during ACCESS: psel=penable=rsp_valid=0 immediately; after release a new command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester.
package apb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_state_t;

endpackage

// File: rtl/apb_master_timer.sv
// ACCESS wait-state counter; saturates at LIMIT and flags expiry.
module apb_master_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == W'(LIMIT));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS out.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_state_t state_q, state_d;
   logic       done, tmo, accept;

   assign done      = (state_q == ACCESS) && pready;
   assign cmd_ready = (state_q == IDLE) || done;
   assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   logic expired;

   // Held in clear outside ACCESS so every ACCESS phase starts from zero.
   apb_master_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q != ACCESS),
      .enable  ((state_q == ACCESS) && !pready),
      .expired (expired)
   );

   assign tmo = (state_q == ACCESS) && !pready && expired;
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYC;
   assign tmo        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS: begin
            if (done)     state_d = accept ? SETUP : IDLE;
            else if (tmo) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state_q   <= state_d;
         if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
         end
         rsp_valid <= done || tmo;
         rsp_err   <= done ? pslverr : tmo;
         // pwrite still describes the finishing transfer at this edge.
         rsp_rdata <= (done && !pwrite && !pslverr) ? prdata : '0;
      end
   end

   assign psel    = (state_q == SETUP) || (state_q == ACCESS);
   assign penable = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_master.sv
// Randomized + directed bench for apb_master with a transaction-level model.
module tb_apb_master;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata, prdata;
   logic       pready, pslverr;

   int checks = 0;
   int errors = 0;

   // model: busy flag, cycles since accept, current command, pending response
   bit         m_busy;
   int         m_age;
   logic       m_w;
   logic [7:0] m_a, m_d;
   bit         e_rv, e_err;
   logic [7:0] e_rd;
   bit         acc;

   always #5 clk = ~clk;

   apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_busy = 0; m_age = 0; m_w = 0; m_a = 0; m_d = 0;
      e_rv = 0; e_err = 0; e_rd = 0;
   endtask

   // One clock: compare registered outputs, drive inputs, check cmd_ready,
   // then advance the model to what the coming edge must produce.
   task automatic step(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input bit rdy, input logic [7:0] prd, input bit err, output bit accepted);
      bit er, done, tmo;
      @(negedge clk);
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_age >= 1);
      chk("pwrite", pwrite, m_w);
      chk("paddr", paddr, m_a);
      chk("pwdata", pwdata, m_d);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_err", rsp_err, e_err);
      chk("rsp_rdata", rsp_rdata, e_rd);
      cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      pready = rdy; prdata = prd; pslverr = err;
      #1;
      er = !m_busy || (m_age >= 1 && rdy);
      chk("cmd_ready", cmd_ready, er);
      accepted = v && er;
      done = m_busy && m_age >= 1 && rdy;
      tmo = 0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo = m_busy && m_age >= 1 && !rdy && (m_age - 1) >= TO;
`endif
      e_rv  = done || tmo;
      e_err = done ? err : tmo;
      e_rd  = (done && !m_w && !err) ? prd : 8'h00;
      if (accepted) begin
         m_busy = 1; m_age = 0; m_w = w; m_a = a; m_d = d;
      end else if (done || tmo) m_busy = 0;
      else if (m_busy) m_age++;
   endtask

   task automatic idle(input bit rdy);
      step(0, 0, 8'h00, 8'h00, rdy, 8'h00, 0, acc);
   endtask

   initial begin
      bit         hv, hw;
      logic [7:0] ha, hd;
      rst = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      pready = 0; prdata = 0; pslverr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset psel", psel, 0);
      chk("reset penable", penable, 0);
      chk("reset paddr", paddr, 0);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset cmd_ready", cmd_ready, 1);
      rst = 1'b1;

      // write 0x5A to 0x10, zero wait
      step(1, 1, 8'h10, 8'h5A, 1, 8'h00, 0, acc);
      chk("wr accepted", acc, 1);
      idle(1);
      chk("wr setup psel", psel, 1);
      chk("wr setup penable", penable, 0);
      chk("wr paddr", paddr, 8'h10);
      chk("wr pwdata", pwdata, 8'h5A);
      idle(1);
      chk("wr access penable", penable, 1);
      idle(1);
      chk("wr rsp_valid", rsp_valid, 1);
      chk("wr rsp_rdata", rsp_rdata, 8'h00);
      chk("wr psel dropped", psel, 0);
      idle(1);

      // read 0x20, three wait states, prdata 0xC3
      step(1, 0, 8'h20, 8'h77, 1, 8'h00, 0, acc);
      idle(0);
      idle(0); idle(0); idle(0);
      chk("rd wait paddr", paddr, 8'h20);
      chk("rd wait penable", penable, 1);
      chk("rd no early rsp", rsp_valid, 0);
      step(0, 0, 8'h00, 8'h00, 1, 8'hC3, 0, acc);
      idle(1);
      chk("rd rsp_valid lat5", rsp_valid, 1);
      chk("rd rsp_rdata", rsp_rdata, 8'hC3);

      // back-to-back write 0x01 then read 0x02
      step(1, 1, 8'h01, 8'hA5, 1, 8'h00, 0, acc);
      step(1, 0, 8'h02, 8'h00, 1, 8'h00, 0, acc);
      step(1, 0, 8'h02, 8'h00, 1, 8'h00, 0, acc);
      chk("b2b second accepted", acc, 1);
      step(0, 0, 8'h00, 8'h00, 1, 8'h00, 0, acc);
      chk("b2b psel held", psel, 1);
      chk("b2b second setup", penable, 0);
      chk("b2b paddr", paddr, 8'h02);
      chk("b2b first rsp", rsp_valid, 1);
      step(0, 0, 8'h00, 8'h00, 1, 8'h9E, 0, acc);
      chk("b2b gap", rsp_valid, 0);
      idle(1);
      chk("b2b second rsp", rsp_valid, 1);
      chk("b2b rdata", rsp_rdata, 8'h9E);

      // read with pslverr
      step(1, 0, 8'h33, 8'h00, 1, 8'h00, 0, acc);
      idle(1);
      step(0, 0, 8'h00, 8'h00, 1, 8'hEE, 1, acc);
      idle(1);
      chk("slverr rsp_err", rsp_err, 1);
      chk("slverr rdata", rsp_rdata, 8'h00);

      // pready held low
      step(1, 0, 8'h44, 8'h00, 1, 8'h00, 0, acc);
      repeat (7) idle(0);
`ifdef APB_MASTER_TIMEOUT_EN
      chk("timeout rsp_valid", rsp_valid, 1);
      chk("timeout rsp_err", rsp_err, 1);
      chk("timeout idle", psel, 0);
`else
      repeat (30) idle(0);
      chk("no timeout psel", psel, 1);
`endif
      idle(1); idle(1); idle(1);

      // reset during ACCESS
      step(1, 0, 8'h55, 8'h00, 1, 8'h00, 0, acc);
      idle(0); idle(0);
      rst = 1'b0;
      cmd_valid = 0;
      #1;
      chk("abort psel", psel, 0);
      chk("abort penable", penable, 0);
      chk("abort rsp_valid", rsp_valid, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1, 1, 8'h66, 8'h12, 1, 8'h00, 0, acc);
      idle(1); idle(1); idle(1);
      chk("post-reset rsp", rsp_valid, 1);
      chk("post-reset paddr", paddr, 8'h66);

      // randomized traffic; a command is held until it is accepted
      hv = 0; hw = 0; ha = 0; hd = 0;
      for (int i = 0; i < 600; i++) begin
         if (!hv) begin
            hv = ($urandom_range(0, 2) != 0);
            hw = $urandom_range(0, 1);
            ha = 8'($urandom);
            hd = 8'($urandom);
         end
         step(hv, hw, ha, hd, $urandom_range(0, 2) != 0, 8'($urandom),
              $urandom_range(0, 5) == 0, acc);
         if (acc) hv = 0;
      end
      repeat (4) idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
